// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: latches floor calls, sweeps in the preferred
// direction, and steps/holds the door on ticks derived from a slow divider level.
module elevator_car_ctrl #(
  parameter int unsigned FLOORS     = 8,
  parameter int unsigned FLOOR_W    = 3,
  parameter int unsigned MOVE_TICKS = 4,
  parameter int unsigned DOOR_TICKS = 6
) (
  input  logic               I_CLK,
  input  logic               rst,
  input  logic               I_TICK,
  input  logic [FLOORS-1:0]  I_REQ,
  output logic [FLOOR_W-1:0] O_FLOOR,
  output logic [1:0]         O_DIR,
  output logic               O_DOOR,
  output logic               O_MOVING,
  output logic [FLOORS-1:0]  O_PENDING
);

  localparam int unsigned MAXT  = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int unsigned CNT_W = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_e;

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               up_q, up_d;
  logic [FLOORS-1:0]  pend_q, pend_d;
  logic               tick_prev_q;

  logic               tick;
  logic [FLOORS-1:0]  p;
  logic [FLOORS-1:0]  served;
  logic [FLOOR_W-1:0] nxt_floor;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (v[i] && (FLOOR_W'(i) > f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (v[i] && (FLOOR_W'(i) < f)) r = 1'b1;
    return r;
  endfunction

  assign tick      = I_TICK & ~tick_prev_q;
  assign p         = pend_q | I_REQ;
  assign nxt_floor = up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    served  = '0;
    unique case (state_q)
      IDLE: begin
        if (p[floor_q]) begin
          state_d         = DOOR_OPEN;
          served[floor_q] = 1'b1;
          cnt_d           = '0;
        end else if (!up_q && any_below(p, floor_q)) begin
          state_d = MOVE;
          up_d    = 1'b0;
          cnt_d   = '0;
        end else if (any_above(p, floor_q)) begin
          state_d = MOVE;
          up_d    = 1'b1;
          cnt_d   = '0;
        end else if (any_below(p, floor_q)) begin
          state_d = MOVE;
          up_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      MOVE: begin
        if (tick) begin
          if (cnt_q == CNT_W'(MOVE_TICKS - 1)) begin
            floor_d = nxt_floor;
            cnt_d   = '0;
            // Arrival decision looks at the floor being entered, not the one left.
            if (p[nxt_floor]) begin
              state_d           = DOOR_OPEN;
              served[nxt_floor] = 1'b1;
            end else if (up_q ? any_above(p, nxt_floor) : any_below(p, nxt_floor)) begin
              state_d = MOVE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DOOR_OPEN: begin
        if (p[floor_q]) begin
          served[floor_q] = 1'b1;
          cnt_d           = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = p & ~served;
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      cnt_q       <= '0;
      up_q        <= 1'b1;
      pend_q      <= '0;
      tick_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      cnt_q       <= cnt_d;
      up_q        <= up_d;
      pend_q      <= pend_d;
      tick_prev_q <= I_TICK;
    end
  end

  always_comb begin
    O_FLOOR   = floor_q;
    O_PENDING = pend_q;
    O_DOOR    = (state_q == DOOR_OPEN);
    O_MOVING  = (state_q == MOVE);
    O_DIR     = (state_q == MOVE) ? (up_q ? 2'b01 : 2'b10) : 2'b00;
  end

endmodule
